// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: command kinds, FSM states and
// the ALU opcode width.
package alu_seq_pkg;

    localparam int ALU_OP_W = 2;

    // Kinds 0..3 map directly onto the ALU opcode through their low bits.
    // 6 and 7 are reserved and answered with an error response.
    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        LOADI = 3'd4,
        READ  = 3'd5
    } cmd_kind_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // ALU kinds are exactly the kinds with bit 2 clear.
    function automatic logic is_alu_kind(input logic [2:0] kind);
        return ~kind[2];
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU command sequencer: NREGS x WIDTH entries,
// two combinational read ports, one synchronous write port, and an
// asynchronous clear on rst_n.
module alu_seq_regfile #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int RAW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RAW-1:0]   rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [RAW-1:0]   rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             wr_en,
    input  logic [RAW-1:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [NREGS];

    // Storage: cleared on reset, one decoded entry written per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en && (wr_addr == RAW'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Read ports see the pre-write contents during a write cycle.
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        rd_data_b = mem[rd_addr_b];
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: accepts register-level commands, drives an external
// combinational ALU, writes results back to its register file and returns
// them on a valid/ready response stream.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds the rsp_zero output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready=1; accept a command, register ALU operands/opcode
// ISSUE | ALU inputs stable for one cycle; capture alu_y into rf and rsp
// RESP  | rsp_valid=1; response held until rsp_ready
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int RAW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_kind,
    input  logic [RAW-1:0]      cmd_dst,
    input  logic [RAW-1:0]      cmd_srca,
    input  logic [RAW-1:0]      cmd_srcb,
    input  logic [WIDTH-1:0]    cmd_imm,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]    alu_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_err
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                rsp_zero
`endif
);

    state_e           state;
    state_e           state_nxt;
    logic             accept;
    logic [RAW-1:0]   lat_dst;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wr_en;
    logic [RAW-1:0]   wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             res_load;
    logic [WIDTH-1:0] res_value;
    logic             res_err;

    // Operand reads are only consumed in IDLE, so the ports follow the
    // command inputs directly.
    alu_seq_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (cmd_srca),
        .rd_data_a (rd_a),
        .rd_addr_b (cmd_srcb),
        .rd_data_b (rd_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: ALU kinds take an extra ISSUE cycle, others answer at once.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = is_alu_kind(cmd_kind) ? ISSUE : RESP;
                end
            end
            ISSUE:   state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshakes, register-file write port and result select.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = cmd_dst;
        wr_data   = cmd_imm;
        res_load  = 1'b0;
        res_value = '0;
        res_err   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    case (cmd_kind)
                        ADD, SUB, AND, OR: begin
                            // Result arrives in ISSUE; only clear the error now.
                            res_load  = 1'b0;
                        end
                        LOADI: begin
                            wr_en     = 1'b1;
                            res_load  = 1'b1;
                            res_value = cmd_imm;
                        end
                        READ: begin
                            res_load  = 1'b1;
                            res_value = rd_a;
                        end
                        default: begin
                            res_load  = 1'b1;
                            res_err   = 1'b1;
                        end
                    endcase
                end
            end
            ISSUE: begin
                wr_en     = 1'b1;
                wr_addr   = lat_dst;
                wr_data   = alu_y;
                res_load  = 1'b1;
                res_value = alu_y;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // ALU drive registers: loaded only on accepting an ALU kind, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            lat_dst <= '0;
        end else if (accept) begin
            lat_dst <= cmd_dst;
            if (is_alu_kind(cmd_kind)) begin
                alu_a  <= rd_a;
                alu_b  <= rd_b;
                alu_op <= cmd_kind[ALU_OP_W-1:0];
            end
        end
    end

    // Response registers: rsp_err tracks the latest accepted command's kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                rsp_err <= res_err;
            end
            if (res_load) begin
                rsp_data <= res_value;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Zero flag follows rsp_data; a reserved kind never reports zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
        end else if (res_load) begin
            rsp_zero <= (res_value == '0) && !res_err;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: inline ALU model, table-driven command
// vectors with a response scoreboard, plus hand-written backpressure and
// mid-operation reset sequences.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_kind;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic       rsp_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] kind;
        logic [1:0] dst;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [3:0] imm;
        logic [3:0] exp_data;
        logic       exp_err;
        logic       exp_zero;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       err;
        logic       zero;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    // External 4-bit ALU model: 0=ADD 1=SUB 2=AND 3=OR.
    always_comb begin
        alu_y = 4'h0;
        case (alu_op)
            2'd0: alu_y = alu_a + alu_b;
            2'd1: alu_y = alu_a - alu_b;
            2'd2: alu_y = alu_a & alu_b;
            2'd3: alu_y = alu_a | alu_b;
            default: alu_y = 4'h0;
        endcase
    end

    alu_cmd_sequencer #(
        .WIDTH (4),
        .NREGS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int k, input int d, input int a, input int b,
                                input int imm, input int ed, input int ee, input int ez);
        vec_t v;
        v.kind     = 3'(k);
        v.dst      = 2'(d);
        v.srca     = 2'(a);
        v.srcb     = 2'(b);
        v.imm      = 4'(imm);
        v.exp_data = 4'(ed);
        v.exp_err  = 1'(ee);
        v.exp_zero = 1'(ez);
        return v;
    endfunction

    function automatic exp_t mk_exp(input int ed, input int ee, input int ez);
        exp_t e;
        e.data = 4'(ed);
        e.err  = 1'(ee);
        e.zero = 1'(ez);
        return e;
    endfunction

    task automatic drive(input vec_t v);
        cmd_kind  = v.kind;
        cmd_dst   = v.dst;
        cmd_srca  = v.srca;
        cmd_srcb  = v.srcb;
        cmd_imm   = v.imm;
        cmd_valid = 1'b1;
    endtask

    // Compare the presented response against the scoreboard head, then
    // complete the handshake. Called at a negedge with rsp_valid expected high.
    task automatic take_rsp(input string name);
        exp_t e;
        chk({name, ".rsp_valid"}, int'(rsp_valid), 1);
        if (sb.size() == 0) begin
            chk({name, ".sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({name, ".rsp_data"}, int'(rsp_data), int'(e.data));
            chk({name, ".rsp_err"}, int'(rsp_err), int'(e.err));
`ifdef ALU_SEQ_FLAGS_EN
            chk({name, ".rsp_zero"}, int'(rsp_zero), int'(e.zero));
`endif
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input vec_t v, input string name);
        int n;
        int lat;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".cmd_ready"}, int'(cmd_ready), 1);
        drive(v);
        sb.push_back(mk_exp(int'(v.exp_data), int'(v.exp_err), int'(v.exp_zero)));
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, lat, (v.kind < 3'd4) ? 2 : 1);
        take_rsp(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // kind dst srca srcb imm | data err zero
        vecs.push_back(mk(5, 0, 0, 0, 0,  0, 0, 1));   // READ r0 after reset
        vecs.push_back(mk(5, 0, 1, 0, 0,  0, 0, 1));   // READ r1
        vecs.push_back(mk(5, 0, 2, 0, 0,  0, 0, 1));   // READ r2
        vecs.push_back(mk(5, 0, 3, 0, 0,  0, 0, 1));   // READ r3
        vecs.push_back(mk(4, 1, 0, 0, 5,  5, 0, 0));   // LOADI r1=5
        vecs.push_back(mk(4, 2, 0, 0, 3,  3, 0, 0));   // LOADI r2=3
        vecs.push_back(mk(0, 0, 1, 2, 0,  8, 0, 0));   // ADD r0=r1+r2
        vecs.push_back(mk(5, 0, 0, 0, 0,  8, 0, 0));   // READ r0
        vecs.push_back(mk(4, 1, 0, 0, 0,  0, 0, 1));   // LOADI r1=0
        vecs.push_back(mk(4, 2, 0, 0, 1,  1, 0, 0));   // LOADI r2=1
        vecs.push_back(mk(1, 3, 1, 2, 0, 15, 0, 0));   // SUB r3=0-1 wraps to F
        vecs.push_back(mk(2, 0, 3, 1, 0,  0, 0, 1));   // AND r0=F&0
        vecs.push_back(mk(3, 2, 3, 1, 0, 15, 0, 0));   // OR r2=F|0
        vecs.push_back(mk(0, 3, 3, 3, 0, 14, 0, 0));   // ADD r3=r3+r3 reads pre-write F
        vecs.push_back(mk(7, 0, 1, 2, 5,  0, 1, 0));   // reserved 7
        vecs.push_back(mk(6, 3, 3, 3, 10, 0, 1, 0));   // reserved 6
        vecs.push_back(mk(5, 0, 0, 0, 0,  0, 0, 1));   // READ r0 unchanged
        vecs.push_back(mk(5, 0, 1, 0, 0,  0, 0, 1));   // READ r1
        vecs.push_back(mk(5, 0, 2, 0, 0, 15, 0, 0));   // READ r2
        vecs.push_back(mk(5, 0, 3, 0, 0, 14, 0, 0));   // READ r3 unchanged by reserved 6

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_kind  = 3'd0;
        cmd_dst   = 2'd0;
        cmd_srca  = 2'd0;
        cmd_srcb  = 2'd0;
        cmd_imm   = 4'd0;
        rsp_ready = 1'b0;
        #1;
        chk("reset.cmd_ready", int'(cmd_ready), 1);
        chk("reset.rsp_valid", int'(rsp_valid), 0);
        chk("reset.rsp_data", int'(rsp_data), 0);
        chk("reset.rsp_err", int'(rsp_err), 0);
        chk("reset.alu_a", int'(alu_a), 0);
        chk("reset.alu_b", int'(alu_b), 0);
        chk("reset.alu_op", int'(alu_op), 0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("reset.rsp_zero", int'(rsp_zero), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            do_cmd(vecs[i], $sformatf("vec%0d", i));
            if (i == 3) begin
                chk("reads.alu_op", int'(alu_op), 0);
            end
        end

        // Backpressure: r1=6, r3=E -> ADD r0 = 4, held for 5 cycles while a
        // second command waits.
        do_cmd(mk(4, 1, 0, 0, 6, 6, 0, 0), "bp.loadi");
        chk("bp.idle_ready", int'(cmd_ready), 1);
        drive(mk(0, 0, 1, 3, 0, 4, 0, 0));
        sb.push_back(mk_exp(4, 0, 0));
        @(negedge clk);
        drive(mk(4, 2, 0, 0, 9, 9, 0, 0));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp.hold%0d.rsp_valid", i), int'(rsp_valid), 1);
            chk($sformatf("bp.hold%0d.rsp_data", i), int'(rsp_data), 4);
            chk($sformatf("bp.hold%0d.cmd_ready", i), int'(cmd_ready), 0);
            @(negedge clk);
        end
        take_rsp("bp.add");
        sb.push_back(mk_exp(9, 0, 0));
        chk("bp.after.cmd_ready", int'(cmd_ready), 1);
        chk("bp.after.rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        take_rsp("bp.second");
        do_cmd(mk(5, 0, 2, 0, 0, 9, 0, 0), "bp.read_r2");
        chk("hold.alu_a", int'(alu_a), 6);
        chk("hold.alu_b", int'(alu_b), 14);
        chk("hold.alu_op", int'(alu_op), 0);

        // Reset while an OR is in ISSUE: no response, register file cleared.
        do_cmd(mk(4, 1, 0, 0, 10, 10, 0, 0), "rst.loadi_r1");
        do_cmd(mk(4, 0, 0, 0, 5, 5, 0, 0), "rst.loadi_r0");
        drive(mk(3, 2, 1, 0, 0, 15, 0, 0));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst.issue.alu_op", int'(alu_op), 3);
        chk("rst.issue.alu_a", int'(alu_a), 10);
        rst_n = 1'b0;
        #1;
        chk("rst.mid.rsp_valid", int'(rsp_valid), 0);
        chk("rst.mid.cmd_ready", int'(cmd_ready), 1);
        chk("rst.mid.alu_op", int'(alu_op), 0);
        chk("rst.mid.alu_a", int'(alu_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst.post%0d.rsp_valid", i), int'(rsp_valid), 0);
        end
        do_cmd(mk(5, 0, 1, 0, 0, 0, 0, 1), "rst.read_r1");
        do_cmd(mk(5, 0, 2, 0, 0, 0, 0, 1), "rst.read_r2");
        do_cmd(mk(5, 0, 0, 0, 0, 0, 0, 1), "rst.read_r0");

        chk("sb.empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
